grid_frame_buffer: RTL
======================

// Module: grid_frame_buffer
// PURPOSE
// Double-buffered game-grid register file between the Avalon-MM slave port and the pixel mapper.
// Software writes a 16-word shadow grid at any time; the shadow is copied to the display grid
// only at the start of vertical sync, so the mapper never renders a half-updated frame.
// Also provides a frame counter and a frame tick so software can pace itself to the display.
// PARAMETERS
// GRID_WORDS  16  number of grid words (shadow and display); the address map is fixed for 16
// WORD_W      16  width of one grid word / Avalon data width
// PORTS
// CLK            in   1               system clock, 50 MHz; vs is synchronous to it
// RESET          in   1               synchronous, active-high reset
// AVL_READ       in   1               Avalon-MM read
// AVL_WRITE      in   1               Avalon-MM write
// AVL_CS         in   1               Avalon-MM chip select; read and write ignored when low
// AVL_ADDR       in   5               word address (map below)
// AVL_WRITEDATA  in   WORD_W          write data
// AVL_READDATA   out  WORD_W          read data, registered, 1-cycle latency
// vs             in   1               VGA vertical sync, active low, from vga_controller
// grid           out  WORD_W x GRID_WORDS  display grid, unpacked array, to the mapper
// frame_tick     out  1               one-cycle pulse per frame
// BEHAVIOUR
// Address map: 0x00-0x0F shadow[i] R/W; 0x10 CTRL; 0x11 FRAME_CNT (RO); 0x12 COMMIT_CNT (RO);
//   0x13-0x1F reserved: writes ignored, reads return 0.
// CTRL write: bit0=1 -> set pending; bit1=1 -> zero all shadow words; bit2 -> auto (stored).
// CTRL read: {13'b0, auto, 1'b0, pending}.
// Reset: shadow, grid, pending, auto, FRAME_CNT, COMMIT_CNT, AVL_READDATA, frame_tick all 0;
//   vs_q (the vs history register) resets to 1, so no edge is seen on the first cycle after reset.
// Frame edge: fe = vs_q & ~vs, where vs_q is vs delayed by one cycle (falling edge of vs).
// On fe: FRAME_CNT += 1, wrapping 0xFFFF -> 0x0000. frame_tick = 1 in the next cycle only.
// Commit on fe when the registered pending = 1 or auto = 1:
//   grid <= shadow (all 16 words in one cycle); pending <= 0; COMMIT_CNT += 1, wrapping.
// Otherwise grid holds its value. grid changes only on a commit or on reset.
// Simultaneous events:
//   - shadow write in a commit cycle -> grid gets the pre-write shadow; shadow takes the new data.
//   - CTRL bit0 write in an fe cycle -> not committed this edge; pending = 1 afterwards.
//   - CTRL bit1 (clear) and bit0 in the same write -> shadow is zeroed; zeros commit next edge.
//   - READ and WRITE together -> the write takes effect; the read returns the pre-write value.
// Reads: AVL_READDATA <= data[addr] the cycle after AVL_CS & AVL_READ; otherwise it holds.
// RESET asserted mid-frame clears everything; the next commit needs a new request or auto.
// No backpressure: every access completes with fixed latency (no waitrequest).
// STRUCTURE
// grid_pkg: GRID_WORDS, WORD_W, CTRL_ADDR=5'h10, FCNT_ADDR=5'h11, CCNT_ADDR=5'h12,
//   CTRL bit indices, typedef logic [WORD_W-1:0] grid_word_t; grid_t = grid_word_t [GRID_WORDS].
// One sub-module: sync_edge_detect (registered falling-edge detect on vs with a 1-cycle pulse
//   output); reusable for hs. Everything else is flat always_ff in this module.
// TESTING
// 1 Reset, then read 0x00-0x12 -> all 0; grid all 0; frame_tick stays 0 until the first vs fall.
// 2 Write shadow[3]=16'hBEEF with no commit; drop vs -> grid[3] stays 0, FRAME_CNT=1, COMMIT_CNT=0.
// 3 Write shadow[3]=16'hBEEF, write CTRL=1, drop vs -> grid[3]=BEEF in the cycle after fe;
//   CTRL reads 0; COMMIT_CNT=1.
// 4 Write CTRL=1 in the same cycle as fe -> no commit; CTRL reads 1; commits on the next fe.
// 5 CTRL=4 (auto); write shadow[0]=1, then 2 across two frames -> grid[0]=1, then 2;
//   COMMIT_CNT increments every frame.
// 6 Preload FRAME_CNT=0xFFFF via 65535 frames (or a force), one more fe -> 0x0000;
//   CTRL=2 zeros the shadow; reads of 0x1F return 0.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants, register map and types for the double-buffered game grid.
package grid_pkg;

    localparam int GRID_WORDS = 16;
    localparam int WORD_W     = 16;
    localparam int ADDR_W     = 5;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = 5'h10;
    localparam logic [ADDR_W-1:0] FCNT_ADDR = 5'h11;
    localparam logic [ADDR_W-1:0] CCNT_ADDR = 5'h12;

    localparam int CTRL_PEND_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_AUTO_BIT = 2;

    typedef logic [WORD_W-1:0] grid_word_t;
    typedef grid_word_t grid_t [GRID_WORDS];

    // CTRL read-back layout: {13'b0, auto, 1'b0, pending}
    function automatic grid_word_t ctrl_word(input logic auto_b, input logic pend_b);
        grid_word_t w;
        w                = '0;
        w[CTRL_AUTO_BIT] = auto_b;
        w[CTRL_PEND_BIT] = pend_b;
        return w;
    endfunction

endpackage

// File: rtl/grid_frame_buffer_if.sv
// Avalon-MM slave bus bundle for the grid frame buffer.
interface grid_frame_buffer_if;
    import grid_pkg::*;

    logic                AVL_READ;
    logic                AVL_WRITE;
    logic                AVL_CS;
    logic [ADDR_W-1:0]   AVL_ADDR;
    logic [WORD_W-1:0]   AVL_WRITEDATA;
    logic [WORD_W-1:0]   AVL_READDATA;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );

endinterface

// File: rtl/grid_frame_buffer_sync_edge_detect.sv
// Registered falling-edge detector with a one-cycle delayed pulse (usable for vs or hs).
module sync_edge_detect #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic sig_i,
    output logic fall_o,
    output logic pulse_o
);

    logic sig_q;
    logic pulse_q;

    // Edge is seen in the same cycle the input drops; history resets to the idle level.
    assign fall_o  = sig_q & ~sig_i;
    assign pulse_o = pulse_q;

    // History register and delayed pulse.
    always_ff @(posedge clk) begin
        if (srst) begin
            sig_q   <= IDLE_LEVEL;
            pulse_q <= 1'b0;
        end else begin
            sig_q   <= sig_i;
            pulse_q <= fall_o;
        end
    end

endmodule

// File: rtl/grid_frame_buffer.sv
// Shadow/display grid register file; shadow is copied to the display at vsync fall.
module grid_frame_buffer
    import grid_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    grid_frame_buffer_if.slave   avl,
    input  logic                 vs,
    output grid_t                grid,
    output logic                 frame_tick
);

    grid_t         shadow_q, shadow_d;
    grid_t         grid_q,   grid_d;
    logic          pending_q;
    logic          auto_q;
    grid_word_t    frame_cnt_q;
    grid_word_t    commit_cnt_q;
    grid_word_t    readdata_q;
    grid_word_t    rd_word;

    logic          fe;
    logic          commit;
    logic          wr_en;
    logic          rd_en;
    logic          ctrl_wr;
    logic          clr_wr;

    sync_edge_detect #(.IDLE_LEVEL(1'b1)) u_vs_edge (
        .clk     (CLK),
        .srst    (RESET),
        .sig_i   (vs),
        .fall_o  (fe),
        .pulse_o (frame_tick)
    );

    assign wr_en   = avl.AVL_CS & avl.AVL_WRITE;
    assign rd_en   = avl.AVL_CS & avl.AVL_READ;
    assign ctrl_wr = wr_en && (avl.AVL_ADDR == CTRL_ADDR);
    assign clr_wr  = ctrl_wr && avl.AVL_WRITEDATA[CTRL_CLR_BIT];
    // Commit uses the registered pending flag, so a request landing on the edge waits a frame.
    assign commit  = fe && (pending_q || auto_q);

    // Per-word next state: grid samples the pre-write shadow; shadow takes the bus write.
    for (genvar gi = 0; gi < GRID_WORDS; gi++) begin : g_word
        assign shadow_d[gi] = clr_wr ? '0 :
                              (wr_en && avl.AVL_ADDR == ADDR_W'(gi)) ? avl.AVL_WRITEDATA :
                              shadow_q[gi];
        assign grid_d[gi]   = commit ? shadow_q[gi] : grid_q[gi];
    end

    // Grid storage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_q <= '{default: '0};
            grid_q   <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            grid_q   <= grid_d;
        end
    end

    assign grid = grid_q;

    // Control flags and frame/commit counters; a new request overrides the commit clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q    <= 1'b0;
            auto_q       <= 1'b0;
            frame_cnt_q  <= '0;
            commit_cnt_q <= '0;
        end else begin
            if (ctrl_wr && avl.AVL_WRITEDATA[CTRL_PEND_BIT]) begin
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
            if (ctrl_wr) begin
                auto_q <= avl.AVL_WRITEDATA[CTRL_AUTO_BIT];
            end
            if (fe) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (commit) begin
                commit_cnt_q <= commit_cnt_q + 1'b1;
            end
        end
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        rd_word = '0;
        if (!avl.AVL_ADDR[ADDR_W-1]) begin
            rd_word = shadow_q[avl.AVL_ADDR[ADDR_W-2:0]];
        end else begin
            case (avl.AVL_ADDR)
                CTRL_ADDR: rd_word = ctrl_word(auto_q, pending_q);
                FCNT_ADDR: rd_word = frame_cnt_q;
                CCNT_ADDR: rd_word = commit_cnt_q;
                default:   rd_word = '0;
            endcase
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_word;
        end
    end

    assign avl.AVL_READDATA = readdata_q;

endmodule
